muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide unit with its own sequencing FSM, sitting in EX beside the ALU. The decoder routes M-extension ops here instead of through the ALU control path. The unit holds the pipeline through `busy` for the whole operation. It produces one result per accepted request, with one-bit-per-cycle (radix-2) shift-add multiply and restoring divide.

## Interface
- `XLEN`, 32, operand/result width (power of two, ≥8)
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request strobe; accepted only when `busy`=0
- `funct3`  in  3  M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `rs1`  in  XLEN  operand A (multiplicand / dividend)
- `rs2`  in  XLEN  operand B (multiplier / divisor)
- `kill`  in  1  flush from branch/exception; aborts current op
- `busy`  out  1  high from the accepting edge until the edge that leaves DONE; stall request to hazard unit
- `done`  out  1  single-cycle result-valid pulse
- `result`  out  XLEN  result; valid while `done`=1; held until the next accept

## Operation
- Reset: `busy`=0, `done`=0, `result`=0, state IDLE, counter 0.
- States: IDLE, CALC, DONE.
- IDLE → CALC on `start`: latch `funct3` and operands, convert signed operands to magnitudes, record the result sign, load counter with XLEN-1.
- CALC: one iteration per cycle; counter decrements; at counter 0 → DONE.
- DONE: apply sign correction and select hi/lo (mul) or quotient/remainder (div), register `result`, assert `done` for 1 cycle → IDLE.
- Multiply: 2·XLEN-bit product accumulator.
  - MUL returns the low half.
  - MULH/MULHSU/MULHU return the high half.
  - Sign handling: MULH treats both operands as signed; MULHSU treats rs1 signed, rs2 unsigned.
- Divide: restoring divide, XLEN+1-bit partial remainder.
  - Quotient sign = sign(A) XOR sign(B).
  - Remainder sign = sign(A).
- Divide by zero:
  - DIV/DIVU quotient = all ones.
  - REM/REMU remainder = rs1.
- Signed overflow (DIV/REM with A = −2^(XLEN−1), B = −1):
  - quotient = −2^(XLEN−1)
  - remainder = 0
- `start` while `busy`=1: ignored, no queuing.
- `kill` in any state:
  - next state IDLE, `busy`=0 next cycle, no `done`.
  - `result` keeps its previous value.
  - `kill` and `done` in the same cycle: the `done` pulse still occurs (instruction already retired by hazard unit), state goes to IDLE.
- `kill` and `start` in the same cycle in IDLE: `kill` wins, nothing accepted.
- `rst` overrides everything, including mid-CALC.

## Timing
- `start` sampled high in cycle c (IDLE) → `busy`=1 from cycle c+1.
- `done`=1 in cycle c+XLEN+1 (c+33 at XLEN=32); `busy` falls in cycle c+XLEN+2.
- Back-to-back: next `start` is accepted no earlier than cycle c+XLEN+2.
  - Throughput: 1 op per XLEN+2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `MULDIV_FASTPATH_EN` defined:
  - Divide-by-zero, signed overflow, and any op with a zero operand for MUL* skip CALC.
  - IDLE → DONE directly; `done` in cycle c+2.
- Undefined:
  - All ops take the full XLEN iterations.
  - Special cases are resolved only in DONE; results are identical either way.

## Structure
- `muldiv_pkg`: funct3 op encodings (`OP_MUL` … `OP_REMU`) and the state encoding (`S_IDLE`, `S_CALC`, `S_DONE`).
- One sub-module, `muldiv_step`: combinational single-iteration datapath.
  - Shift-add step for multiply.
  - Trial-subtract/restore step for divide.
  - Selected by a mul/div flag.
- FSM, counter, operand latching and sign fix-up stay in `muldiv_unit`.

## Test plan
- MUL rs1=7, rs2=0xFFFFFFFD → `done` at c+33, `result`=0xFFFFFFEB; `busy` high c+1..c+33.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULH same operands → 0x00000000. MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0.
  - With `MULDIV_FASTPATH_EN`: `done` at c+2 for these cases.
  - Without it: `done` at c+33.
- `kill` at c+10 of a DIV → `busy`=0 at c+11, no `done`, `result` unchanged. New MUL 3×4 started at c+11 → 12 at c+44.
- `rst` at c+5 mid-CALC → `busy`=0, `done`=0, `result`=0 next cycle. `start` during `busy` is ignored (result reflects the first op only).

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 op encodings, FSM states and op-classification helpers.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  function automatic logic op_is_div(input op_t op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic op_is_rem(input op_t op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  function automatic logic op_a_signed(input op_t op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_b_signed(input op_t op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, trial-subtract/restore for
// divide. hi holds the product high half / partial remainder, lo the
// multiplier / dividend-then-quotient.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] addend,
  output logic [XLEN-1:0] hi_next,
  output logic [XLEN-1:0] lo_next
);

  logic [XLEN-1:0] add_sel;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic            fits;

  assign add_sel = lo[0] ? addend : '0;
  assign sum     = {1'b0, hi} + {1'b0, add_sel};
  assign shifted = {hi, lo[XLEN-1]};
  assign fits    = shifted >= {1'b0, addend};

  always_comb begin
    hi_next = sum[XLEN:1];
    lo_next = {sum[0], lo[XLEN-1:1]};
    if (is_div) begin
      // True difference is below the divisor, so modulo-2^XLEN subtract is exact.
      if (fits) begin
        hi_next = shifted[XLEN-1:0] - addend;
        lo_next = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_next = shifted[XLEN-1:0];
        lo_next = {lo[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (XLEN iterations per op).
// Optional MULDIV_FASTPATH_EN: zero-operand multiplies and divide special cases skip CALC.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state, state_n;
  logic [CW-1:0]   cnt;
  op_t             op, op_in;
  logic [XLEN-1:0] a_raw, b_raw, addend, hi, lo;
  logic [XLEN-1:0] hi_nx, lo_nx, a_mag, b_mag, res_n;
  logic            neg_q, neg_r, a_neg_in, b_neg_in, fast_in;
  logic            busy_q, done_q, done_n;
  logic [XLEN-1:0] result_q;

  assign op_in    = op_t'(funct3);
  assign a_neg_in = op_a_signed(op_in) & rs1[XLEN-1];
  assign b_neg_in = op_b_signed(op_in) & rs2[XLEN-1];
  assign a_mag    = a_neg_in ? -rs1 : rs1;
  assign b_mag    = b_neg_in ? -rs2 : rs2;

`ifdef MULDIV_FASTPATH_EN
  assign fast_in = op_is_div(op_in)
                 ? (rs2 == '0 || (op_b_signed(op_in) && rs1 == MIN_NEG && rs2 == '1))
                 : (rs1 == '0 || rs2 == '0);
`else
  assign fast_in = 1'b0;
`endif

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div  (op_is_div(op)),
    .hi      (hi),
    .lo      (lo),
    .addend  (addend),
    .hi_next (hi_nx),
    .lo_next (lo_nx)
  );

  // Special cases override the iterative value so both builds agree bit-for-bit.
  function automatic logic [XLEN-1:0] fixup(
    input op_t f, input logic [XLEN-1:0] ar, br, h, l, input logic nq, nr);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   r;
    prod = {h, l};
    if (nq) prod = -prod;
    case (f)
      OP_MUL:                      r = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: r = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             r = nq ? -l : l;
      default:                     r = nr ? -h : h;
    endcase
    if (!op_is_div(f) && (ar == '0 || br == '0)) begin
      r = '0;
    end else if (op_is_div(f) && br == '0) begin
      r = op_is_rem(f) ? ar : '1;
    end else if (op_b_signed(f) && op_is_div(f) && ar == MIN_NEG && br == '1) begin
      r = op_is_rem(f) ? '0 : MIN_NEG;
    end
    return r;
  endfunction

  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    res_n   = result_q;
    case (state)
      S_IDLE: if (start && !kill) state_n = fast_in ? S_DONE : S_CALC;
      S_CALC: begin
        if (kill) begin
          state_n = S_IDLE;
        end else if (cnt == '0) begin
          state_n = S_DONE;
          done_n  = 1'b1;
          res_n   = fixup(op, a_raw, b_raw, hi_nx, lo_nx, neg_q, neg_r);
        end
      end
      // Fast-path entry arrives with done_q low and spends one cycle registering the result.
      S_DONE: begin
        if (kill || done_q) begin
          state_n = S_IDLE;
        end else begin
          done_n = 1'b1;
          res_n  = fixup(op, a_raw, b_raw, hi, lo, neg_q, neg_r);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state  <= state_n;
      busy_q <= (state_n != S_IDLE);
      done_q <= done_n;
      if (done_n) result_q <= res_n;
      if (state == S_IDLE) cnt <= CW'(XLEN-1);
      else if (state == S_CALC) cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      op    <= op_in;
      a_raw <= rs1;
      b_raw <= rs2;
      neg_q <= a_neg_in ^ b_neg_in;
      neg_r <= a_neg_in;
      hi    <= '0;
      lo     <= op_is_div(op_in) ? a_mag : b_mag;
      addend <= op_is_div(op_in) ? b_mag : a_mag;
    end else if (state == S_CALC) begin
      hi <= hi_nx;
      lo <= lo_nx;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit against a plain-arithmetic RV32M model.
// Honours MULDIV_FASTPATH_EN for the expected completion latency.
module tb_muldiv_unit;

  localparam logic [31:0] MIN_NEG = 32'h8000_0000;
  localparam int LIMIT = 100;

  logic        clk = 1'b0;
  logic        rst, start, kill;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .rs1    (rs1),
    .rs2    (rs2),
    .kill   (kill),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] xa, xb, p;
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (f < 3'd4) begin
      xa = (f == 3'd1 || f == 3'd2) ? {{32{a[31]}}, a} : {32'd0, a};
      xb = (f == 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
      p  = xa * xb;
      return (f == 3'd0) ? p[31:0] : p[63:32];
    end
    if (b == 32'd0) return (f >= 3'd6) ? a : 32'hFFFF_FFFF;
    if ((f == 3'd4 || f == 3'd6) && a == MIN_NEG && b == 32'hFFFF_FFFF)
      return (f == 3'd6) ? 32'd0 : MIN_NEG;
    case (f)
      3'd4:    return sa / sb;
      3'd5:    return a / b;
      3'd6:    return sa % sb;
      default: return a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_FASTPATH_EN
    if (f >= 3'd4) begin
      if (b == 32'd0 || ((f == 3'd4 || f == 3'd6) && a == MIN_NEG && b == 32'hFFFF_FFFF)) return 2;
    end else if (a == 32'd0 || b == 32'd0) begin
      return 2;
    end
`endif
    return 33;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one op in the current cycle c and follows it to completion.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input string tag, input bit poke);
    logic [31:0] exp;
    int lat, cyc;
    bit busy_ok;
    exp = ref_result(f, a, b);
    lat = exp_lat(f, a, b);
    funct3 = f; rs1 = a; rs2 = b; start = 1'b1;
    tick();
    start = 1'b0;
    funct3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
    cyc = 1;
    busy_ok = 1'b1;
    while (!done && cyc < LIMIT) begin
      if (!busy) busy_ok = 1'b0;
      if (poke && cyc == 4) begin
        start = 1'b1; funct3 = 3'd0; rs1 = 32'd9; rs2 = 32'd9;
      end
      tick();
      start = 1'b0;
      cyc++;
    end
    if (!busy) busy_ok = 1'b0;
    check({tag, "_lat"}, 32'(cyc), 32'(lat));
    check({tag, "_res"}, result, exp);
    check({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
    tick();
    check({tag, "_end"}, {30'd0, busy, done}, 32'd0);
  endtask

  task automatic quiet(input string tag, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      if (busy || done) seen++;
      tick();
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  vec_t dir[$];
  logic [31:0] prev;
  int seen_done;

  initial begin
    rst = 1'b1; start = 1'b0; kill = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0;
    repeat (3) tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    rst = 1'b0;
    tick();

    dir = '{
      '{3'd0, 32'd7, 32'hFFFF_FFFD},
      '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
      '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
      '{3'd2, 32'hFFFF_FFFF, 32'd2},
      '{3'd4, 32'hFFFF_FFF9, 32'd2},
      '{3'd6, 32'hFFFF_FFF9, 32'd2},
      '{3'd5, 32'd100, 32'd7},
      '{3'd7, 32'd100, 32'd7},
      '{3'd5, 32'd5, 32'd0},
      '{3'd6, 32'd5, 32'd0},
      '{3'd4, MIN_NEG, 32'hFFFF_FFFF},
      '{3'd6, MIN_NEG, 32'hFFFF_FFFF},
      '{3'd0, 32'd0, 32'd1234}
    };
    foreach (dir[i]) run_op(dir[i].f, dir[i].a, dir[i].b, $sformatf("dir%0d", i), 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] f;
      logic [31:0] a, b;
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: a = 32'd0;
        2: begin a = MIN_NEG; b = 32'hFFFF_FFFF; end
        3: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
        default: ;
      endcase
      run_op(f, a, b, $sformatf("rnd%0d", i), 1'b0);
    end

    run_op(3'd5, 32'd1000, 32'd10, "poke", 1'b1);
    quiet("poke_quiet", 40);

    // Kill during CALC of a DIV issued in cycle c.
    prev = result;
    funct3 = 3'd4; rs1 = 32'd1000; rs2 = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    seen_done = 0;
    for (int i = 1; i < 10; i++) begin
      if (done) seen_done++;
      tick();
    end
    if (done) seen_done++;
    kill = 1'b1;
    tick();
    kill = 1'b0;
    if (done) seen_done++;
    check("kill_busy", {31'd0, busy}, 32'd0);
    check("kill_nodone", 32'(seen_done), 32'd0);
    check("kill_result", result, prev);
    run_op(3'd0, 32'd3, 32'd4, "after_kill", 1'b0);

    // Reset mid-CALC clears the result register too.
    funct3 = 3'd5; rs1 = 32'd77; rs2 = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_result", result, 32'd0);
    quiet("midrst_quiet", 40);

    // Kill and start together in IDLE: nothing is accepted.
    funct3 = 3'd0; rs1 = 32'd5; rs2 = 32'd6; start = 1'b1; kill = 1'b1;
    tick();
    start = 1'b0; kill = 1'b0;
    quiet("killstart_quiet", 40);
    check("killstart_result", result, 32'd0);

    run_op(3'd7, 32'hDEAD_BEEF, 32'd1000, "final", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
